rr_arbiter4: RTL
================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive cycles one requester may hold a grant (legal 1..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 en  input  1  arbiter enable; low forces no grant.
REQ-005 req  input  4  request vector; bit i is requester i, level-held until served.
REQ-006 gnt  output  4  one-hot grant, registered; 4'b0000 when no grant.
REQ-007 gnt_id  output  2  binary index of the granted requester (0001->0, 0010->1, 0100->2, 1000->3); 2'b00 when no grant.
REQ-008 gnt_valid  output  1  high exactly when gnt is non-zero.

Function
REQ-009 The arbiter SHALL implement two states: IDLE (no grant) and GRANT (one owner).
REQ-010 In IDLE with en=1 and req!=0, the arbiter SHALL select the first set req bit scanning ptr, ptr+1, ... modulo 4, and enter GRANT at the next edge.
REQ-011 Grant latency SHALL be one cycle: req sampled at edge k produces registered gnt visible after edge k.
REQ-012 In IDLE with en=0 or req=0, the arbiter SHALL stay in IDLE with gnt=0, gnt_id=0, gnt_valid=0.
REQ-013 In GRANT, the grant SHALL be held while en=1, req[owner]=1 and hold_cnt < MAX_HOLD.
REQ-014 hold_cnt SHALL be 8 bits, load 1 on entering GRANT, increment each held cycle; gnt is high for at most MAX_HOLD consecutive cycles.
REQ-015 Release on req[owner]=0 or hold_cnt=MAX_HOLD SHALL return to IDLE at the next edge and set ptr = owner+1 modulo 4 (3 wraps to 0).
REQ-016 Release on en=0 SHALL return to IDLE at the next edge with ptr unchanged.
REQ-017 Every release SHALL produce exactly one cycle with gnt=0 before any new grant (no back-to-back handoff).
REQ-018 Requests by non-owners during GRANT SHALL be ignored until the IDLE cycle, then arbitrated per REQ-010.
REQ-019 gnt SHALL never have more than one bit set; gnt_id and gnt_valid SHALL be consistent with gnt in every cycle.
REQ-020 If req[owner] drops on the same cycle the timeout is reached, a single release with ptr = owner+1 SHALL occur.

Reset
REQ-021 rst_n low SHALL immediately, without a clock edge, force state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, ptr=0, hold_cnt=0.
REQ-022 Reset asserted mid-grant SHALL abort the grant; after rst_n rises, arbitration SHALL restart from ptr=0.
REQ-023 The first rising edge after rst_n deassertion SHALL behave as a normal IDLE edge.

Structure
REQ-024 A shared package arb_pkg SHALL hold the state encoding (IDLE=0, GRANT=1), requester count 4, and the index width 2.
REQ-025 The rotating priority select SHALL be a combinational sub-module rr_pick4 (inputs req[3:0], ptr[1:0]; outputs one-hot pick[3:0], pick_id[1:0], pick_valid).
REQ-026 All outputs SHALL be driven directly from flops; no combinational path from req or en to outputs.

Verification
REQ-027 Reset: rst_n=0 with req=4'b1111, en=1 -> gnt=0000, gnt_id=0, gnt_valid=0 throughout, also asynchronously mid-cycle.
REQ-028 Single requester: en=1, req=0100 for 3 cycles then 0000 -> gnt=0100, gnt_id=2 from the cycle after the first req, held 3 cycles, 0000 the cycle after req drops.
REQ-029 Fairness and timeout: MAX_HOLD=4, req=1111 constant -> owners 0,1,2,3,0 in order, each exactly 4 grant cycles separated by one idle cycle.
REQ-030 Skip and wrap: after owner 1 releases, req=1010 -> next grant 1000 (id 3), then 0010 (id 1).
REQ-031 Enable drop: en falls during owner 2 grant -> gnt=0000 next cycle; en rises with req=1111 -> owner 2 granted again (ptr unchanged).
REQ-032 Mid-grant reset: rst_n pulsed low during owner 3 grant -> outputs 0 immediately; after release with req=1111, owner 0 granted first.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// The state encoding is fixed (IDLE=0, GRANT=1) so it can be decoded outside the arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int HOLD_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0]   req_idx_t;
  typedef logic [HOLD_W-1:0]  hold_cnt_t;

  function automatic req_vec_t idx_to_onehot(input req_idx_t idx);
    return req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority select: the first set request at or after ptr, wrapping modulo 4.
// Purely combinational; all registering happens in the arbiter.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] pick,
  output logic [1:0] pick_id,
  output logic       pick_valid
);

  req_idx_t cand;

  // NOTE: every signal driven here is assigned a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    pick       = '0;
    pick_id    = '0;
    pick_valid = 1'b0;
    cand       = '0;
    // Scan from the farthest offset down so the nearest hit to ptr wins last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        pick_id    = cand;
        pick_valid = 1'b1;
      end
    end
    if (pick_valid) begin
      pick = idx_to_onehot(pick_id);
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time per grant.
// Every release passes through one idle cycle before the next grant is issued.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  localparam hold_cnt_t HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  arb_state_e state, state_d;
  req_idx_t   owner, owner_d;
  req_idx_t   ptr, ptr_d;
  hold_cnt_t  hold_cnt, hold_cnt_d;
  req_vec_t   gnt_d;
  req_idx_t   gnt_id_d;
  logic       gnt_valid_d;

  req_vec_t   pick;
  req_idx_t   pick_id;
  logic       pick_valid;

  rr_pick4 u_pick (
    .req        (req),
    .ptr        (ptr),
    .pick       (pick),
    .pick_id    (pick_id),
    .pick_valid (pick_valid)
  );

  always_comb begin
    state_d     = state;
    owner_d     = owner;
    ptr_d       = ptr;
    hold_cnt_d  = hold_cnt;
    gnt_d       = gnt;
    gnt_id_d    = gnt_id;
    gnt_valid_d = gnt_valid;

    case (state)
      IDLE: begin
        if (en && pick_valid) begin
          state_d     = GRANT;
          owner_d     = pick_id;
          hold_cnt_d  = hold_cnt_t'(1);
          gnt_d       = pick;
          gnt_id_d    = pick_id;
          gnt_valid_d = 1'b1;
        end else begin
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
        end
      end

      GRANT: begin
        if (!en || !req[owner] || hold_cnt >= HOLD_LIMIT) begin
          state_d     = IDLE;
          hold_cnt_d  = '0;
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          // An enable drop aborts without rotating, so the same owner wins again.
          if (en) begin
            ptr_d = owner + req_idx_t'(1);
          end
        end else begin
          hold_cnt_d = hold_cnt + hold_cnt_t'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        hold_cnt_d  = '0;
        gnt_d       = '0;
        gnt_id_d    = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      ptr       <= ptr_d;
      hold_cnt  <= hold_cnt_d;
      gnt       <= gnt_d;
      gnt_id    <= gnt_id_d;
      gnt_valid <= gnt_valid_d;
    end
  end

endmodule
